// File: rtl/oam_dma_ctrl.sv
// CPU-bus DMA engine: snoops a trigger write, halts the CPU, then copies LEN bytes
// from {page,8'h00} upward into a fixed destination port.
module oam_dma_ctrl #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] DST_ADDR  = 16'h2004,
    parameter logic [15:0] INIT_ADDR = 16'h2003,
    parameter bit          INIT_EN   = 1'b1,
    parameter int unsigned LEN       = 256,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] cpumc_a_in,
    input  logic [7:0]  cpumc_din_in,
    input  logic [7:0]  cpumc_dout_in,
    input  logic        cpu_r_nw_in,
    input  logic        abort_in,
    output logic        active_out,
    output logic        done_out,
    output logic [15:0] cpumc_a_out,
    output logic [7:0]  cpumc_d_out,
    output logic        cpumc_r_nw_out,
    output logic [10:0] xfer_cnt_out
);

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StInit,
        StRead,
        StWrite,
        StCooldown
    } state_e;

    localparam logic [10:0] LastIdx = 11'(LEN - 1);
    localparam logic [1:0]  LastLat = 2'(RD_LAT);

    state_e      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [10:0] idx_q, idx_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  lat_q, lat_d;
    logic        done_q, done_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            page_q  <= 8'h00;
            idx_q   <= 11'd0;
            cnt_q   <= 11'd0;
            data_q  <= 8'h00;
            lat_q   <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            lat_q   <= lat_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        lat_d   = lat_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpumc_a_in == TRIG_ADDR && !cpu_r_nw_in) begin
                    page_d  = cpumc_din_in;
                    idx_d   = 11'd0;
                    cnt_d   = 11'd0;
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (cpu_r_nw_in) begin
                    state_d = INIT_EN ? StInit : StRead;
                    lat_d   = 2'd0;
                end
            end
            StInit: begin
                state_d = StRead;
                lat_d   = 2'd0;
            end
            StRead: begin
                // Address is held steady, so data is valid on the last READ cycle.
                if (lat_q == LastLat) begin
                    data_d  = cpumc_dout_in;
                    state_d = StWrite;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            StWrite: begin
                cnt_d = cnt_q + 11'd1;
                if (idx_q == LastIdx) begin
                    state_d = StCooldown;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 11'd1;
                    lat_d   = 2'd0;
                    state_d = StRead;
                end
            end
            StCooldown: begin
                if (cpu_r_nw_in) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Abort beats completion, even when it lands on the final write.
        if (abort_in && state_q != StIdle) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        active_out     = 1'b0;
        cpumc_a_out    = 16'h0000;
        cpumc_d_out    = 8'h00;
        cpumc_r_nw_out = 1'b1;
        unique case (state_q)
            StHalt: active_out = 1'b1;
            StInit: begin
                active_out     = 1'b1;
                cpumc_a_out    = INIT_ADDR;
                cpumc_r_nw_out = 1'b0;
            end
            StRead: begin
                active_out  = 1'b1;
                cpumc_a_out = {page_q, 8'h00} + {5'b00000, idx_q};
            end
            StWrite: begin
                active_out     = 1'b1;
                cpumc_a_out    = DST_ADDR;
                cpumc_d_out    = data_q;
                cpumc_r_nw_out = 1'b0;
            end
            default: ;
        endcase
    end

    assign done_out     = done_q;
    assign xfer_cnt_out = cnt_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Drives three differently parameterised DMA instances from one CPU bus and checks each
// against a cycle-offset model of the expected write stream, counts and pulses.
module tb_oam_dma_ctrl;

    localparam logic [15:0] TrigAddr = 16'h4014;
    localparam logic [15:0] DstAddr  = 16'h2004;
    localparam logic [15:0] InitAddr = 16'h2003;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_din;
    logic        cpu_rnw;
    logic        abort;

    logic [7:0]  dout  [3];
    logic        act   [3];
    logic        done  [3];
    logic [15:0] a_o   [3];
    logic [7:0]  d_o   [3];
    logic        rnw_o [3];
    logic [10:0] cnt_o [3];

    logic [7:0]  mem [0:65535];
    logic [15:0] apipe [3][3];
    logic [41:0] wr_log [$];
    int          act_cnt [3];
    int          done_cnt [3];
    int          cyc = 0;
    int          base;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    oam_dma_ctrl u_def (
        .clk_in(clk), .rst_in(rst), .cpumc_a_in(cpu_a), .cpumc_din_in(cpu_din),
        .cpumc_dout_in(dout[0]), .cpu_r_nw_in(cpu_rnw), .abort_in(abort),
        .active_out(act[0]), .done_out(done[0]), .cpumc_a_out(a_o[0]),
        .cpumc_d_out(d_o[0]), .cpumc_r_nw_out(rnw_o[0]), .xfer_cnt_out(cnt_o[0])
    );

    oam_dma_ctrl #(.INIT_EN(1'b0), .LEN(4), .RD_LAT(2)) u_l2 (
        .clk_in(clk), .rst_in(rst), .cpumc_a_in(cpu_a), .cpumc_din_in(cpu_din),
        .cpumc_dout_in(dout[1]), .cpu_r_nw_in(cpu_rnw), .abort_in(abort),
        .active_out(act[1]), .done_out(done[1]), .cpumc_a_out(a_o[1]),
        .cpumc_d_out(d_o[1]), .cpumc_r_nw_out(rnw_o[1]), .xfer_cnt_out(cnt_o[1])
    );

    oam_dma_ctrl #(.LEN(512), .RD_LAT(3)) u_wrap (
        .clk_in(clk), .rst_in(rst), .cpumc_a_in(cpu_a), .cpumc_din_in(cpu_din),
        .cpumc_dout_in(dout[2]), .cpu_r_nw_in(cpu_rnw), .abort_in(abort),
        .active_out(act[2]), .done_out(done[2]), .cpumc_a_out(a_o[2]),
        .cpumc_d_out(d_o[2]), .cpumc_r_nw_out(rnw_o[2]), .xfer_cnt_out(cnt_o[2])
    );

    // Memory returns the byte for the address presented RD_LAT cycles earlier.
    assign dout[0] = mem[apipe[0][0]];
    assign dout[1] = mem[apipe[1][1]];
    assign dout[2] = mem[apipe[2][2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            apipe[k][2] <= apipe[k][1];
            apipe[k][1] <= apipe[k][0];
            apipe[k][0] <= a_o[k];
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            act_cnt[k]  <= act_cnt[k] + (act[k] ? 1 : 0);
            done_cnt[k] <= done_cnt[k] + (done[k] ? 1 : 0);
            if (!rnw_o[k]) wr_log.push_back({2'(k), 16'(cyc - base), a_o[k], d_o[k]});
        end
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic int init_of(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int len_of(input int k);
        return (k == 0) ? 256 : ((k == 1) ? 4 : 512);
    endfunction

    // Offsets are counted from the first HALT cycle; h is the number of HALT cycles.
    function automatic int first_w(input int k, input int h);
        return h + init_of(k) + lat_of(k) + 1;
    endfunction

    function automatic int last_w(input int k, input int h);
        return first_w(k, h) + (len_of(k) - 1) * (lat_of(k) + 2);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp_writes(input int k, input int h, input logic [7:0] page, input int cut,
                              input int log0, output int ndata);
        logic [41:0] e[$];
        logic [41:0] g[$];
        logic [15:0] src;
        int          off, n, bad;
        ndata = 0;
        if (init_of(k) == 1 && h <= cut) e.push_back({2'(k), 16'(h), InitAddr, 8'h00});
        for (int j = 0; j < len_of(k); j++) begin
            off = first_w(k, h) + j * (lat_of(k) + 2);
            if (off <= cut) begin
                src = {page, 8'h00} + 16'(j);
                e.push_back({2'(k), 16'(off), DstAddr, mem[src]});
                ndata++;
            end
        end
        for (int i = log0; i < wr_log.size(); i++)
            if (wr_log[i][41:40] == 2'(k)) g.push_back(wr_log[i]);
        check($sformatf("nwr%0d", k), 64'(g.size()), 64'(e.size()));
        n   = (g.size() < e.size()) ? g.size() : e.size();
        bad = -1;
        for (int i = 0; i < n; i++) if (g[i] !== e[i] && bad < 0) bad = i;
        if (bad >= 0) check($sformatf("wr%0d", k), 64'(g[bad]), 64'(e[bad]));
        else if (n > 0) check($sformatf("wr%0d", k), 64'(g[n-1]), 64'(e[n-1]));
    endtask

    task automatic run_xfer(input logic [7:0] page, input int hold, input int ab,
                            input bit cd_req);
        int h, cut, cd_off, end_off, log0, nd, lim;
        int a0[3];
        int d0[3];
        bit cd;
        h      = hold + 1;
        cut    = (ab < 0) ? 32'h3fffffff : ab;
        cd_off = last_w(1, h) + 1;
        cd     = cd_req && (ab < 0 || ab >= cd_off);
        end_off = cd_off + 3;
        for (int k = 0; k < 3; k++) begin
            lim = (last_w(k, h) < cut) ? last_w(k, h) : cut;
            if (lim + 4 > end_off) end_off = lim + 4;
        end
        log0 = wr_log.size();
        for (int k = 0; k < 3; k++) begin
            a0[k] = act_cnt[k];
            d0[k] = done_cnt[k];
        end
        @(posedge clk); #1;
        cpu_a = TrigAddr; cpu_din = page; cpu_rnw = 1'b0;
        base = cyc + 1;
        for (int off = 0; off <= end_off; off++) begin
            @(posedge clk); #1;
            cpu_din = 8'h00;
            if (off < hold) begin
                cpu_a = 16'h0100; cpu_rnw = 1'b0;
            end else begin
                cpu_a = 16'h8000; cpu_rnw = 1'b1;
            end
            // A trigger landing in the short instance's COOLDOWN must be ignored.
            if (cd && off == cd_off) begin
                cpu_a = TrigAddr; cpu_din = ~page; cpu_rnw = 1'b0;
            end
            abort = (off == ab);
            if (off < h && off <= cut)
                check("halt", 64'({act[0], rnw_o[0], a_o[0]}), 64'({1'b1, 1'b1, 16'h0000}));
            if (off == h && h <= cut)
                check("init", 64'({act[0], a_o[0], d_o[0], rnw_o[0]}),
                      64'({1'b1, InitAddr, 8'h00, 1'b0}));
        end
        abort = 1'b0; cpu_a = 16'h8000; cpu_rnw = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmp_writes(k, h, page, cut, log0, nd);
            check($sformatf("cnt%0d", k), 64'(cnt_o[k]), 64'(nd));
            lim = (last_w(k, h) < cut) ? last_w(k, h) : cut;
            check($sformatf("active%0d", k), 64'(act_cnt[k] - a0[k]), 64'(lim + 1));
            check($sformatf("done%0d", k), 64'(done_cnt[k] - d0[k]),
                  64'((last_w(k, h) < cut) ? 1 : 0));
        end
    endtask

    task automatic run_reset(input logic [7:0] page);
        int log0, nd;
        log0 = wr_log.size();
        @(posedge clk); #1;
        cpu_a = TrigAddr; cpu_din = page; cpu_rnw = 1'b0;
        base = cyc + 1;
        for (int off = 0; off <= 2; off++) begin
            @(posedge clk); #1;
            cpu_a = 16'h8000; cpu_din = 8'h00; cpu_rnw = 1'b1;
        end
        check("rd_addr", 64'(a_o[0]), 64'({page, 8'h00}));
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("rst_out%0d", k),
                  64'({act[k], done[k], a_o[k], d_o[k], rnw_o[k], cnt_o[k]}),
                  64'({1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 11'd0}));
        @(posedge clk); @(posedge clk); #3 rst = 1'b0;
        for (int k = 0; k < 3; k++) cmp_writes(k, 1, page, 1, log0, nd);
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("idle%0d", k), 64'(act[k]), 64'(0));
    endtask

    initial begin
        logic [7:0] p;
        int         hold, ab;
        rst = 1'b1; cpu_a = 16'h8000; cpu_din = 8'h00; cpu_rnw = 1'b1; abort = 1'b0; base = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'h5A;
        #12;
        for (int k = 0; k < 3; k++)
            check($sformatf("rst_val%0d", k),
                  64'({act[k], done[k], a_o[k], d_o[k], rnw_o[k], cnt_o[k]}),
                  64'({1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 11'd0}));
        #10 rst = 1'b0;
        run_xfer(8'h02, 3, -1, 1'b1);
        run_xfer(8'hFF, 0, -1, 1'b0);
        p = 8'($urandom);
        run_xfer(p, 0, first_w(0, 1) + 9 * (lat_of(0) + 2), 1'b0);
        run_xfer(p + 8'd1, 0, -1, 1'b0);
        run_reset(8'hA5);
        for (int t = 0; t < 4; t++) begin
            p    = 8'($urandom);
            hold = $urandom_range(0, 3);
            ab   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2700)) : -1;
            run_xfer(p, hold, ab, $urandom_range(0, 1) == 1);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
